// File: rtl/avg_unpooling_layer.sv
// avg_unpooling_layer
// Backward end of a 2x2 average pool: each signed pooled sample is scaled by
// 2**-SHIFT and replicated into its 2x2 window, producing a raster-order
// (2*IN_H) x (2*IN_W) output stream with a one-entry output register.
// Pooled row r is expanded twice: ROW_A takes new samples and stores them in a
// line buffer, ROW_B replays the line buffer for the second output row.
module avg_unpooling_layer #(
    parameter int IN_W   = 14,
    parameter int IN_H   = 14,
    parameter int DATA_W = 16,
    parameter int SHIFT  = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_last,
    output logic                     finished
);

    localparam int COL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int ROW_W = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IN_W - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW_A = 2'd1,
        ST_ROW_B = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                     state_q;
    logic [ROW_W-1:0]           row_q;
    logic [COL_W-1:0]           col_q;
    logic                       dup_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic                       out_last_q;
    logic                       finished_q;

    // Scaled samples of the pooled row currently being expanded (not reset).
    logic signed [DATA_W-1:0]   line_buf_q [IN_W];

    logic                       slot_free_s;
    logic                       step_s;
    logic                       in_ready_s;
    logic                       accept_s;
    logic                       col_last_s;
    logic                       row_last_s;
    logic signed [DATA_W-1:0]   scaled_s;
    logic signed [DATA_W-1:0]   buf_rd_s;
    logic [COL_W-1:0]           col_d;
    logic [ROW_W-1:0]           row_d;

    // Handshake qualifiers, scaling and counter next values.
    always_comb begin
        slot_free_s = !out_valid_q || out_ready;
        step_s      = enable && slot_free_s;
        if ((state_q == ST_ROW_A) && !dup_q) begin
            in_ready_s = step_s;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s   = in_ready_s && in_valid;
        // Arithmetic shift keeps the sign and rounds toward minus infinity.
        scaled_s   = in_data >>> SHIFT;
        buf_rd_s   = line_buf_q[col_q];
        col_last_s = (col_q == COL_MAX);
        row_last_s = (row_q == ROW_MAX);
        if (col_last_s) begin
            col_d = {COL_W{1'b0}};
        end else begin
            col_d = col_q + COL_W'(1);
        end
        if (row_last_s) begin
            row_d = {ROW_W{1'b0}};
        end else begin
            row_d = row_q + ROW_W'(1);
        end
    end

    // Capture each accepted scaled sample for replay on the second output row.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            line_buf_q[col_q] <= scaled_s;
        end
    end

    // Frame sequencer with the output register; a load overrides a retire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            row_q       <= {ROW_W{1'b0}};
            col_q       <= {COL_W{1'b0}};
            dup_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            out_last_q  <= 1'b0;
            finished_q  <= 1'b0;
        end else begin
            if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    finished_q <= 1'b0;
                    if (enable) begin
                        state_q <= ST_ROW_A;
                        row_q   <= {ROW_W{1'b0}};
                        col_q   <= {COL_W{1'b0}};
                        dup_q   <= 1'b0;
                    end
                end
                ST_ROW_A: begin
                    if (accept_s) begin
                        out_data_q  <= scaled_s;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        dup_q       <= 1'b1;
                    end else if (dup_q && step_s) begin
                        // Second copy of the sample is read back from the buffer.
                        out_data_q  <= buf_rd_s;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        dup_q       <= 1'b0;
                        col_q       <= col_d;
                        if (col_last_s) begin
                            state_q <= ST_ROW_B;
                        end
                    end
                end
                ST_ROW_B: begin
                    if (step_s) begin
                        out_data_q  <= buf_rd_s;
                        out_valid_q <= 1'b1;
                        out_last_q  <= dup_q && col_last_s && row_last_s;
                        dup_q       <= !dup_q;
                        if (dup_q) begin
                            col_q <= col_d;
                            if (col_last_s) begin
                                row_q <= row_d;
                                if (row_last_s) begin
                                    state_q    <= ST_DONE;
                                    finished_q <= 1'b1;
                                end else begin
                                    state_q <= ST_ROW_A;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    finished_q <= 1'b1;
                    if (!enable) begin
                        state_q    <= ST_IDLE;
                        finished_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    finished_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign finished  = finished_q;

endmodule

// File: tb/tb_avg_unpooling_layer.sv
// Self-checking bench for avg_unpooling_layer: directed frames compared beat
// by beat against a pixel-to-pooled-index model, plus literal pins.
module tb_avg_unpooling_layer;

    localparam int NIN  = 196;
    localparam int NOUT = 784;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic in_valid = 1'b0;
    logic in_ready;
    logic signed [15:0] in_data = 16'sd0;
    logic out_valid;
    logic out_ready = 1'b0;
    logic signed [15:0] out_data;
    logic out_last;
    logic finished;

    // Second build with SHIFT=0 on a 2x2 pooled map.
    logic e2 = 1'b0;
    logic iv2 = 1'b0;
    logic ir2;
    logic signed [15:0] id2 = 16'sd0;
    logic ov2;
    logic or2 = 1'b0;
    logic signed [15:0] od2;
    logic ol2;
    logic f2;

    int tests_run = 0;
    int tests_failed = 0;

    logic signed [15:0] frame_in [NIN];
    logic signed [15:0] got [NOUT];
    int in_idx, beat_cnt, valid_pct, ready_pct;
    bit prev_stall;
    logic signed [15:0] prev_data;
    logic prev_last;

    always #5 clk = ~clk;

    avg_unpooling_layer #(.IN_W(14), .IN_H(14), .DATA_W(16), .SHIFT(2)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .finished(finished)
    );

    avg_unpooling_layer #(.IN_W(2), .IN_H(2), .DATA_W(16), .SHIFT(0)) dut_s0 (
        .clk(clk), .reset(reset), .enable(e2),
        .in_valid(iv2), .in_ready(ir2), .in_data(id2),
        .out_valid(ov2), .out_ready(or2), .out_data(od2),
        .out_last(ol2), .finished(f2)
    );

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Output pixel (r,c) comes from pooled sample (r/2, c/2), scaled by 1/4.
    function automatic logic signed [15:0] exp_pix(input int b);
        int r, c;
        logic signed [15:0] v;
        r = b / 28;
        c = b % 28;
        v = frame_in[(r / 2) * 14 + c / 2];
        return v >>> 2;
    endfunction

    // Compare step, called once per cycle at the falling edge.
    task automatic monitor();
        if (!reset) begin
            if (prev_stall) begin
                check("stall_valid_held", int'(out_valid), 1);
                check("stall_data_held", int'(out_data), int'(prev_data));
                check("stall_last_held", int'(out_last), int'(prev_last));
            end
            if (!enable) begin
                check("in_ready_while_disabled", int'(in_ready), 0);
            end
            if (out_valid && out_ready) begin
                if (beat_cnt < NOUT) begin
                    check($sformatf("pixel[%0d]", beat_cnt), int'(out_data), int'(exp_pix(beat_cnt)));
                    check($sformatf("out_last[%0d]", beat_cnt), int'(out_last), int'(beat_cnt == NOUT - 1));
                    got[beat_cnt] = out_data;
                end else begin
                    check("beat_in_frame", beat_cnt, NOUT - 1);
                end
                beat_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    endtask

    task automatic drive();
        in_valid  = (in_idx < NIN) && ($urandom_range(0, 99) < valid_pct);
        if (in_valid) begin
            in_data = frame_in[in_idx];
        end else begin
            in_data = 16'sh5A5A;
        end
        out_ready = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        if (in_valid && in_ready) in_idx++;
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic mid_frame_reset();
        #2;
        reset = 1'b1;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 0);
        check("reset_finished", int'(finished), 0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        enable     = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        prev_stall = 1'b0;
        beat_cnt   = 0;
        repeat (2) tick();
    endtask

    task automatic run_frame(input int vpct, input int rpct, input int pause_at,
                             input int abort_at, output int cycles);
        int start;
        bit paused;
        in_idx     = 0;
        beat_cnt   = 0;
        valid_pct  = vpct;
        ready_pct  = rpct;
        prev_stall = 1'b0;
        paused     = 1'b0;
        cycles     = 0;
        enable     = 1'b1;
        drive();
        while (beat_cnt < NOUT && cycles < 20000) begin
            if (beat_cnt == abort_at) begin
                mid_frame_reset();
                return;
            end
            if (beat_cnt == pause_at && !paused) begin
                paused = 1'b1;
                start  = beat_cnt;
                enable = 1'b0;
                repeat (10) tick();
                check("pause_only_pending_retires", beat_cnt - start, 1);
                enable = 1'b1;
            end
            tick();
            cycles++;
        end
        check("frame_complete", beat_cnt, NOUT);
        check("inputs_consumed", in_idx, NIN);
        tick();
        check("finished_after_last", int'(finished), 1);
        check("idle_output_after_last", int'(out_valid), 0);
        repeat (3) tick();
        check("finished_held", int'(finished), 1);
        check("no_beats_in_done", beat_cnt, NOUT);
        enable = 1'b0;
        repeat (2) tick();
        check("finished_falls", int'(finished), 0);
    endtask

    logic signed [15:0] vals2 [4];
    logic signed [15:0] got2 [16];

    initial begin
        int cyc;
        int b2, idx2;
        logic signed [15:0] e;

        // Reset state
        #12;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_finished", int'(finished), 0);
        check("rst_out_last", int'(out_last), 0);
        check("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) tick();

        // Constant 400 -> 100 everywhere, full rate
        for (int k = 0; k < NIN; k++) frame_in[k] = 16'sd400;
        run_frame(100, 100, -1, -1, cyc);
        check("const_beat0", int'(got[0]), 100);
        check("const_beat783", int'(got[783]), 100);
        check("full_rate_cycles_le_790", int'(cyc <= 790), 1);

        // Ramp 4k, full rate, enable pause during ROW_B at col 5
        for (int k = 0; k < NIN; k++) frame_in[k] = 16'(4 * k);
        run_frame(100, 100, 38, -1, cyc);
        check("ramp_beat28", int'(got[28]), 0);
        check("ramp_beat57", int'(got[57]), 14);
        check("ramp_beat783", int'(got[783]), 195);

        // Ramp with random gaps and back-pressure
        run_frame(70, 50, -1, -1, cyc);
        check("rand_beat57", int'(got[57]), 14);

        // Sign and range extremes
        for (int k = 0; k < NIN; k++) frame_in[k] = 16'(k * 331 - 30000);
        frame_in[0] = -16'sd5;
        frame_in[1] = -16'sd32768;
        frame_in[2] = 16'sd32767;
        frame_in[3] = 16'sd5;
        run_frame(80, 60, -1, -1, cyc);
        check("sign_m5", int'(got[0]), -2);
        check("sign_m5_dup", int'(got[29]), -2);
        check("sign_min", int'(got[2]), -8192);
        check("sign_max", int'(got[4]), 8191);
        check("sign_p5", int'(got[6]), 1);

        // Asynchronous reset after 300 beats, then a clean frame
        for (int k = 0; k < NIN; k++) frame_in[k] = 16'(4 * k);
        run_frame(90, 70, -1, 300, cyc);
        run_frame(90, 70, -1, -1, cyc);
        check("post_reset_beat783", int'(got[783]), 195);

        // SHIFT=0 build: plain 2x2 replication
        vals2[0] = -16'sd5;
        vals2[1] = 16'sd1234;
        vals2[2] = -16'sd32768;
        vals2[3] = 16'sd32767;
        b2   = 0;
        idx2 = 0;
        e2   = 1'b1;
        or2  = 1'b1;
        iv2  = 1'b1;
        id2  = vals2[0];
        for (int c = 0; c < 100 && b2 < 16; c++) begin
            @(negedge clk);
            if (ov2 && or2) begin
                e = vals2[((b2 / 4) / 2) * 2 + (b2 % 4) / 2];
                check($sformatf("s0_pixel[%0d]", b2), int'(od2), int'(e));
                check($sformatf("s0_last[%0d]", b2), int'(ol2), int'(b2 == 15));
                got2[b2] = od2;
                b2++;
            end
            if (iv2 && ir2) idx2++;
            @(posedge clk);
            #1;
            iv2 = (idx2 < 4);
            if (idx2 < 4) id2 = vals2[idx2];
            else id2 = 16'sd0;
        end
        check("s0_frame_complete", b2, 16);
        @(negedge clk);
        check("s0_finished", int'(f2), 1);
        check("s0_pin_b2", int'(got2[2]), 1234);
        check("s0_pin_b5", int'(got2[5]), -5);
        check("s0_pin_b8", int'(got2[8]), -32768);
        check("s0_pin_b10", int'(got2[10]), 32767);
        e2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
